// File: rtl/beam_tx_pkg.sv
// beam_tx_pkg: shared state encoding, sizing helper and defaults for the beam transmit sequencer
package beam_tx_pkg;
  typedef enum logic [2:0] {IDLE, ARM, GUARD_ON, FIRE, GUARD_OFF, GAP, FINISH} state_t;
  localparam int DEF_GUARD_CYC = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/beam_transmit_sequencer_tx_channel.sv
// tx_channel: per-channel delay down-counter and pulse shift register
module tx_channel import beam_tx_pkg::*; #(
  parameter int DELAY_W = 16,
  parameter int PULSE_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 run,
  input  logic [DELAY_W-1:0]   delay,
  input  logic [PULSE_LEN-1:0] shape,
  output logic                 pulse,
  output logic                 sent
);
  localparam int RW = clog2_min1(PULSE_LEN + 1);
  logic [DELAY_W-1:0] cnt;
  logic [PULSE_LEN-1:0] sh;
  logic [RW-1:0] rem;
  logic fire;
  assign fire = run && enable && cnt == '0 && rem != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh <= '0;
      rem <= '0;
      pulse <= 1'b0;
      sent <= 1'b0;
    end else if (load) begin
      cnt <= delay;
      sh <= shape;
      rem <= RW'(PULSE_LEN);
      pulse <= 1'b0;
      sent <= 1'b0;
    end else begin
      pulse <= fire && sh[0];
      if (run && (!enable || (cnt == '0 && rem == '0))) sent <= 1'b1;
      if (run && enable && cnt != '0) cnt <= cnt - DELAY_W'(1);
      if (fire) begin
        sh <= sh >> 1;
        rem <= rem - RW'(1);
      end
    end
  end
endmodule

// File: rtl/beam_transmit_sequencer.sv
// beam_transmit_sequencer: delay-steered multi-channel, multi-burst ultrasound transmit sequencer
module beam_transmit_sequencer import beam_tx_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int DELAY_W = 16,
  parameter int PULSE_LEN = 32,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int BURST_W = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic [clog2_min1(NUM_CH)-1:0]   cfg_ch,
  input  logic [DELAY_W-1:0]              cfg_delay,
  input  logic [NUM_CH-1:0]               ch_enable,
  input  logic [PULSE_LEN-1:0]            pulse_shape,
  input  logic [BURST_W-1:0]              burst_count,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic                            cfg_err,
  output logic [NUM_CH-1:0]               tx_pulses,
  output logic [NUM_CH-1:0]               ch_sent,
  output logic                            switch_en
);
  localparam int GC_W = clog2_min1(GUARD_CYC);
  state_t state, nxt;
  logic [GC_W-1:0] gcnt;
  logic [BURST_W-1:0] bursts;
  logic [NUM_CH-1:0] act_en;
  logic [PULSE_LEN-1:0] act_shape;
  logic [DELAY_W-1:0] delay_reg [NUM_CH];
  logic [DELAY_W-1:0] act_delay [NUM_CH];
  logic abort_hit, gdone, load, run;
  assign abort_hit = abort && state != IDLE;
  assign gdone = gcnt == '0;
  assign load = abort_hit || state == ARM || state == GAP;
  assign run = nxt == FIRE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start ? ARM : IDLE;
      ARM:       nxt = GUARD_ON;
      GUARD_ON:  nxt = gdone ? FIRE : GUARD_ON;
      FIRE:      nxt = &ch_sent ? GUARD_OFF : FIRE;
      GUARD_OFF: nxt = !gdone ? GUARD_OFF : (bursts != '0) ? GAP : FINISH;
      GAP:       nxt = GUARD_ON;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort_hit) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gcnt <= '0;
      bursts <= '0;
      act_en <= '0;
      act_shape <= '0;
      act_delay <= '{default: '0};
      delay_reg <= '{default: '0};
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      switch_en <= 1'b0;
    end else begin
      state <= nxt;
      gcnt <= (nxt != state) ? GC_W'(GUARD_CYC - 1) : gcnt - GC_W'(!gdone);
      busy <= nxt != IDLE;
      done <= nxt == FINISH;
      aborted <= abort_hit;
      cfg_err <= cfg_we && state != IDLE;
      switch_en <= nxt inside {GUARD_ON, FIRE, GUARD_OFF};
      if (state == IDLE && start) begin
        act_en <= ch_enable;
        act_shape <= pulse_shape;
        act_delay <= delay_reg;
        bursts <= burst_count - BURST_W'(burst_count != '0);
      end else if (state == GAP) begin
        bursts <= bursts - BURST_W'(1);
      end
      if (cfg_we && state == IDLE && 32'(cfg_ch) < NUM_CH) delay_reg[cfg_ch] <= cfg_delay;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tx_channel #(.DELAY_W(DELAY_W), .PULSE_LEN(PULSE_LEN)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .enable(act_en[c]),
      .load(load),
      .run(run),
      .delay(act_delay[c]),
      .shape(act_shape),
      .pulse(tx_pulses[c]),
      .sent(ch_sent[c])
    );
  end
endmodule

// File: doc/beam_transmit_sequencer.md
Name: beam_transmit_sequencer

Overview:
- Parametrised successor to the fixed 8-channel A-line transmit FSM.
- Fires a delay-steered ultrasound pulse on NUM_CH channels, with per-channel delays written through an indexed config port.
- Adds T/R switch guard intervals, multi-pulse bursts per A-line, per-channel enables and abort.
- Sits between the host config/control logic and the pulser drivers.

Parameters:
- NUM_CH, 8, number of transmit channels (1..64)
- DELAY_W, 16, width of each channel delay in clk cycles
- PULSE_LEN, 32, pulse shape length in bits/cycles
- GUARD_CYC, 4, cycles switch_en is held before first and after last pulse bit (>=1)
- BURST_W, 4, width of burst_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write cfg_delay into delay register cfg_ch
- cfg_ch  in  $clog2(NUM_CH)  channel index for config write
- cfg_delay  in  DELAY_W  delay value for channel cfg_ch
- ch_enable  in  NUM_CH  per-channel enable, latched at start
- pulse_shape  in  PULSE_LEN  pulse bit pattern, bit 0 sent first, latched at start
- burst_count  in  BURST_W  pulses per A-line, latched at start; 0 treated as 1
- start  in  1  begin A-line transmit (sampled in IDLE only)
- abort  in  1  terminate immediately
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse on normal completion of all bursts
- aborted  out  1  one-cycle pulse when abort ends a sequence
- cfg_err  out  1  one-cycle pulse when cfg_we is asserted while busy (write dropped)
- tx_pulses  out  NUM_CH  per-channel pulse drive
- ch_sent  out  NUM_CH  per-channel flag: pulse finished in current burst
- switch_en  out  1  T/R switch enable, active high

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - All outputs = 0.
  - Delay registers = 0.
  - Latched config = 0.
- Config writes:
  - cfg_we in IDLE: cfg_delay is written to register cfg_ch at the edge; visible to the next start.
  - cfg_we while busy: write is dropped and cfg_err pulses the next cycle.
  - cfg_ch >= NUM_CH: write ignored, no error.
- States: IDLE, ARM, GUARD_ON, FIRE, GUARD_OFF, GAP, FINISH. All outputs are registered.
- IDLE:
  - start=1 at edge k moves to ARM.
  - busy=1 after edge k.
  - ch_enable, pulse_shape, burst_count and all delays are copied to an active set.
  - Later config writes or input changes do not affect the running sequence.
- ARM (1 cycle): channel counters are loaded from the active delays; → GUARD_ON.
- GUARD_ON (GUARD_CYC cycles): switch_en=1; → FIRE.
- FIRE:
  - Let cycle 0 be the first FIRE cycle. An enabled channel with delay d drives pulse_shape[i] on tx_pulses[c] in FIRE cycle d+i, for i = 0..PULSE_LEN-1.
  - At all other times tx_pulses[c]=0.
  - ch_sent[c] is set the cycle after bit PULSE_LEN-1 is driven.
  - Disabled channels: tx_pulses[c]=0 always; ch_sent[c]=1 from FIRE cycle 0.
  - When all ch_sent bits are 1 → GUARD_OFF. If all channels are disabled, FIRE lasts exactly 1 cycle.
- GUARD_OFF (GUARD_CYC cycles): switch_en stays 1, tx_pulses=0.
  - Then, if bursts remain: → GAP.
  - Otherwise: → FINISH.
- GAP (1 cycle):
  - switch_en=0.
  - ch_sent cleared.
  - Counters reloaded.
  - Burst counter decremented.
  - → GUARD_ON.
- FINISH (1 cycle):
  - switch_en=0, done=1.
  - → IDLE; busy falls after FINISH.
- switch_en rule: switch_en is never 0 while any tx_pulses bit is 1; this is an assertion for verification.
- abort: when high at any edge with state != IDLE:
  - → IDLE next cycle.
  - tx_pulses, switch_en and ch_sent are zeroed.
  - aborted pulses, done is not asserted.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort has priority over every transition.
  - start while busy is ignored.
  - start and abort together in IDLE: start is accepted.
- Delay width: delay = 2^DELAY_W-1 is legal. FIRE length is max enabled delay + PULSE_LEN + 1 cycles, with no wrap-around.

Decomposition:
- Package beam_tx_pkg:
  - state encodings;
  - a clog2 helper;
  - default GUARD_CYC.
- Sub-module tx_channel, instantiated NUM_CH times via generate, containing:
  - DELAY_W down-counter;
  - PULSE_LEN shift register;
  - enable, load, run inputs;
  - pulse and sent outputs.

Test Plan:
- NUM_CH=8; delays 0,1,2..7; all enabled; pulse_shape=32'h0000_00FF; burst_count=1.
  - Expected: switch_en rises 2 cycles after start.
  - FIRE begins 4 cycles later.
  - Channel c pulses high for FIRE cycles c..c+7.
  - done occurs once, 4+1 cycles after ch_sent==8'hFF.
- ch_enable=8'b0000_0101: channels 1,3-7 stay 0 with ch_sent=1 from FIRE cycle 0; sequence completes on channels 0 and 2 only.
- burst_count=3 → exactly 3 GUARD_ON/FIRE/GUARD_OFF groups with a 1-cycle switch_en=0 GAP between them; one done pulse.
- abort asserted in FIRE cycle 5 → next cycle tx_pulses=0, switch_en=0, aborted=1, done never pulses; new start is accepted afterwards.
- cfg_we to channel 3 while busy → cfg_err=1 for one cycle; next A-line uses the old delay. Same write in IDLE takes effect on the next A-line.
- rst_n driven low mid-FIRE, off clock edge → all outputs 0 immediately, without waiting for clk; delay registers read back as 0 (a second A-line fires all channels at FIRE cycle 0).
